// File: rtl/press_pkg.sv
// Shared definitions for the press classifier.
//   - Event codes presented on the event queue output.
//   - FSM state encoding for the press-grouping state machine.
package press_pkg;

  typedef logic [1:0] evt_code_t;

  // Event codes: the code value equals the number of presses in the group.
  localparam evt_code_t EVT_NONE   = 2'b00;
  localparam evt_code_t EVT_SINGLE = 2'b01;
  localparam evt_code_t EVT_DOUBLE = 2'b10;
  localparam evt_code_t EVT_TRIPLE = 2'b11;

  // Grouping FSM states: presses seen so far in the current group.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ONE  = 2'd1;
  localparam logic [1:0] ST_TWO  = 2'd2;

endpackage

// File: rtl/press_classifier_if.sv
// Event handshake between the press classifier (master) and its consumer (slave).
//   evt_valid_o : head event present
//   evt_code_o  : head event code (press_pkg EVT_*)
//   evt_ready_i : consumer accepts the head when high with evt_valid_o
interface press_classifier_if;
  logic       evt_valid_o;
  logic [1:0] evt_code_o;
  logic       evt_ready_i;

  modport master (output evt_valid_o, output evt_code_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_code_o, output evt_ready_i);
endinterface

// File: rtl/press_classifier_evt_fifo.sv
// evt_fifo: small synchronous FIFO for classified events.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when full and popping)
//   push_data  : entry to write
//   pop        : remove the head (ignored when empty)
//   full/empty : occupancy flags, from registered state
//   head       : head entry, forced to zero when empty
// All outputs derive from registers only; push/pop affect them after the edge.
module evt_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  logic do_pop;
  logic do_push;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // When full, a write is still accepted if the head leaves in the same
  // cycle: the write slot equals the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/press_classifier.sv
// press_classifier: groups debounced press pulses separated by at most
// WINDOW_CYCLES cycles and classifies each group as single/double/triple.
// Classified events are queued and drained over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   press_i    : one press per cycle high
//   evt        : event handshake (valid, code, ready), master side
//   drop_o     : one-cycle pulse when an event is lost to a full queue
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 12_500_000,
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                press_i,
  press_classifier_if.master  evt,
  output logic                drop_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             drop_reg, drop_next;

  logic             push;
  evt_code_t        push_code;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  evt_code_t        fifo_head;

  // Grouping FSM. A press always takes priority over a timeout in the same
  // cycle, so a press landing exactly on the window edge extends the group.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    push       = 1'b0;
    push_code  = EVT_NONE;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (press_i) begin
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (press_i) begin
          state_next = ST_TWO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          push       = 1'b1;
          push_code  = EVT_SINGLE;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_TWO: begin
        if (press_i) begin
          // Third press closes the group at once; no window wait.
          push       = 1'b1;
          push_code  = EVT_TRIPLE;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          push       = 1'b1;
          push_code  = EVT_DOUBLE;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign pop = !fifo_empty && evt.evt_ready_i;

  // A push into a full queue is lost only if nothing leaves in that cycle.
  assign drop_next = push && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      drop_reg  <= drop_next;
    end
  end

  evt_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign evt.evt_valid_o = !fifo_empty;
  assign evt.evt_code_o  = fifo_head;
  assign drop_o          = drop_reg;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier with WINDOW_CYCLES=8, FIFO_DEPTH=4.
// A timestamp-based model of press groups and an event queue is checked
// against the DUT on every falling edge; directed checks pin exact latencies.
module tb_press_classifier;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic press;
  logic drop;

  int total;
  int bad;

  press_classifier_if evt_bus ();

  press_classifier #(
    .WINDOW_CYCLES (W),
    .CNT_W         (4),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .press_i (press),
    .evt     (evt_bus),
    .drop_o  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A group is the number of presses so far plus the time of the last one.
  // It closes with its press count once W cycles pass with no new press,
  // or immediately on the third press.
  logic [1:0] m_q[$];
  int         m_presses;
  int         m_last;
  int         cyc;
  bit         m_drop;
  bit         m_pop;
  bit         m_emit;
  logic [1:0] m_code;
  int         m_pre;

  initial begin
    m_presses = 0; m_last = 0; cyc = 0; m_drop = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_presses = 0;
        m_last    = 0;
        cyc       = 0;
        m_drop    = 0;
      end else begin
        cyc++;
        m_pre  = m_q.size();
        m_pop  = (m_pre > 0) && evt_bus.evt_ready_i;
        m_emit = 0;
        m_code = 2'b00;
        if (press) begin
          if (m_presses == 2) begin
            m_emit = 1; m_code = 2'd3; m_presses = 0;
          end else begin
            m_presses++; m_last = cyc;
          end
        end else if (m_presses > 0 && (cyc - m_last) == W) begin
          m_emit = 1; m_code = 2'(m_presses); m_presses = 0;
        end
        m_drop = 0;
        if (m_pop) begin
          $display("evt accepted: code=%0d cyc=%0d", m_q[0], cyc);
          void'(m_q.pop_front());
        end
        if (m_emit) begin
          if (m_pre == DEPTH && !m_pop) m_drop = 1;
          else m_q.push_back(m_code);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       exp_valid;
  logic [1:0] exp_code;

  initial begin
    forever begin
      @(negedge clk);
      exp_valid = (m_q.size() > 0);
      exp_code  = exp_valid ? m_q[0] : 2'b00;
      total++;
      if (evt_bus.evt_valid_o !== exp_valid) begin
        bad++;
        $display("FAIL cmp_valid cyc=%0d got=%0b want=%0b", cyc, evt_bus.evt_valid_o, exp_valid);
      end
      total++;
      if (evt_bus.evt_code_o !== exp_code) begin
        bad++;
        $display("FAIL cmp_code cyc=%0d got=%0d want=%0d", cyc, evt_bus.evt_code_o, exp_code);
      end
      total++;
      if (drop !== m_drop) begin
        bad++;
        $display("FAIL cmp_drop cyc=%0d got=%0b want=%0b", cyc, drop, m_drop);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press is high for exactly one sampling edge.
  task automatic do_press();
    press = 1'b1;
    @(posedge clk);
    #1;
    press = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    press = 1'b0;
    evt_bus.evt_ready_i = 1'b1;
    wait_edges(3);
    chk("reset_valid", 4'(evt_bus.evt_valid_o), 4'd0);
    chk("reset_code",  4'(evt_bus.evt_code_o),  4'd0);
    chk("reset_drop",  4'(drop),                4'd0);
    rst_n = 1'b1;
    wait_edges(2);

    // Single: valid exactly W edges after the press, lives one cycle.
    do_press();
    wait_edges(W - 1);
    chk("single_early", 4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(1);
    chk("single_valid", 4'(evt_bus.evt_valid_o), 4'd1);
    chk("single_code",  4'(evt_bus.evt_code_o),  4'd1);
    wait_edges(1);
    chk("single_gone",  4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(3);

    // Double: presses 5 apart, event W after the second press.
    do_press();
    wait_edges(4);
    do_press();
    wait_edges(W - 1);
    chk("double_early", 4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(1);
    chk("double_valid", 4'(evt_bus.evt_valid_o), 4'd1);
    chk("double_code",  4'(evt_bus.evt_code_o),  4'd2);
    wait_edges(3);

    // Triple: presses 4 apart, event right after the third; then a new group.
    do_press();
    wait_edges(3);
    do_press();
    wait_edges(3);
    do_press();
    chk("triple_valid", 4'(evt_bus.evt_valid_o), 4'd1);
    chk("triple_code",  4'(evt_bus.evt_code_o),  4'd3);
    do_press();
    wait_edges(W - 1);
    chk("after_triple_early", 4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(1);
    chk("after_triple_code",  4'(evt_bus.evt_code_o),  4'd1);
    wait_edges(3);

    // Second press exactly on the timeout edge: press wins, double follows.
    do_press();
    wait_edges(W - 1);
    do_press();
    chk("edge_no_single", 4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(W - 1);
    chk("edge_early",     4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(1);
    chk("edge_double",    4'(evt_bus.evt_code_o),  4'd2);
    wait_edges(3);

    // Overflow: five singles with ready low; the fifth is dropped.
    evt_bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_press();
      wait_edges(W + 1);
    end
    chk("fill_code", 4'(evt_bus.evt_code_o), 4'd1);
    do_press();
    wait_edges(W - 1);
    chk("drop_before", 4'(drop), 4'd0);
    wait_edges(1);
    chk("drop_pulse",  4'(drop), 4'd1);
    wait_edges(1);
    chk("drop_end",    4'(drop), 4'd0);
    evt_bus.evt_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 4'(evt_bus.evt_valid_o), 4'd1);
      chk("drain_code",  4'(evt_bus.evt_code_o),  4'd1);
      wait_edges(1);
    end
    chk("drain_empty", 4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(2);

    // Reset mid-group with two queued events.
    evt_bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_press();
      wait_edges(W + 1);
    end
    do_press();
    wait_edges(3);
    do_press();
    chk("pre_reset_valid", 4'(evt_bus.evt_valid_o), 4'd1);
    rst_n = 1'b0;
    #2;
    chk("async_reset_valid", 4'(evt_bus.evt_valid_o), 4'd0);
    chk("async_reset_code",  4'(evt_bus.evt_code_o),  4'd0);
    wait_edges(2);
    rst_n = 1'b1;
    evt_bus.evt_ready_i = 1'b1;
    wait_edges(1);
    do_press();
    wait_edges(W - 1);
    chk("post_reset_early", 4'(evt_bus.evt_valid_o), 4'd0);
    wait_edges(1);
    chk("post_reset_valid", 4'(evt_bus.evt_valid_o), 4'd1);
    chk("post_reset_code",  4'(evt_bus.evt_code_o),  4'd1);
    wait_edges(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
